// File: rtl/rx_tx_pkg.sv
// rtl/rx_tx_pkg.sv - shared Ethernet framing constants, state type and CRC-32 byte update
package rx_tx_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int BYTE_CNT_W = 11;

  localparam logic [7:0]  PREAMBLE_BYTE        = 8'h55;
  localparam logic [7:0]  SFD_BYTE             = 8'hD5;
  localparam int          MIN_FRAME_SIZE       = 64;
  localparam int          MAX_FRAME_SIZE       = 1518;
  localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT           = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    DRAIN,
    IFG
  } tx_state_t;

  // Reflected CRC-32: fold one byte in LSB first, shifting right once per bit.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFLECTED) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_tx_framer_rst_sync.sv
// rtl/eth_tx_framer_rst_sync.sv - async-assert, sync-deassert reset synchronizer
module eth_tx_framer_rst_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst_n
);

  logic [1:0] r_sync;

  // Reset asserts immediately; release ripples through two flops before reaching the core.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  assign o_rst_n = r_sync[1];

endmodule

// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - Ethernet transmit framer: preamble, SFD, payload, pad, FCS, IFG
module eth_tx_framer #(
  parameter int IFG_BYTES  = 12,
  parameter int DATA_WIDTH = rx_tx_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n_in,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_en,
  output logic                  tx_er,
  output logic                  frame_done,
  output logic                  err_pulse
);

  import rx_tx_pkg::*;

  localparam int AUX_W = (IFG_BYTES > 8) ? ($clog2(IFG_BYTES) + 1) : 4;
  localparam logic [BYTE_CNT_W-1:0] PAD_LIMIT      = BYTE_CNT_W'(MIN_FRAME_SIZE - 4);
  localparam logic [BYTE_CNT_W-1:0] OVERSIZE_LIMIT = BYTE_CNT_W'(MAX_FRAME_SIZE - 4);
  localparam logic [AUX_W-1:0]      PRE_LAST       = AUX_W'(6);
  localparam logic [AUX_W-1:0]      FCS_LAST       = AUX_W'(3);
  localparam logic [AUX_W-1:0]      IFG_LAST       = AUX_W'(IFG_BYTES - 1);

  logic                  w_rst_n;
  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [BYTE_CNT_W-1:0] w_byte_cnt_nxt;
  logic [BYTE_CNT_W-1:0] w_byte_cnt_inc;
  logic [AUX_W-1:0]      r_aux_cnt;
  logic [AUX_W-1:0]      w_aux_cnt_nxt;
  logic [31:0]           r_crc;
  logic [31:0]           w_crc_nxt;
  logic [31:0]           w_fcs_shift;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [DATA_WIDTH-1:0] w_tx_data_nxt;
  logic                  r_tx_en;
  logic                  w_tx_en_nxt;
  logic                  r_tx_er;
  logic                  w_tx_er_nxt;
  logic                  r_err_pulse;
  logic                  w_err_nxt;
  logic                  r_fcs_last;
  logic                  w_fcs_last_nxt;
  logic                  r_frame_done;
  logic                  w_s_ready;

  eth_tx_framer_rst_sync u_rst_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n_in),
    .o_rst_n (w_rst_n)
  );

  assign w_byte_cnt_inc = (r_byte_cnt == '1) ? r_byte_cnt : (r_byte_cnt + BYTE_CNT_W'(1));
  assign w_fcs_shift    = (~r_crc) >> {r_aux_cnt[1:0], 3'b000};

  // Next state and the byte to register onto the PHY bus this clock.
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_aux_cnt_nxt  = r_aux_cnt;
    w_crc_nxt      = r_crc;
    w_tx_data_nxt  = '0;
    w_tx_en_nxt    = 1'b0;
    w_tx_er_nxt    = 1'b0;
    w_err_nxt      = 1'b0;
    w_fcs_last_nxt = 1'b0;
    w_s_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_valid) begin
          w_state_nxt   = PREAMBLE;
          w_tx_en_nxt   = 1'b1;
          w_tx_data_nxt = PREAMBLE_BYTE;
          w_aux_cnt_nxt = AUX_W'(1);
        end
      end
      PREAMBLE: begin
        w_tx_en_nxt   = 1'b1;
        w_tx_data_nxt = PREAMBLE_BYTE;
        w_aux_cnt_nxt = r_aux_cnt + AUX_W'(1);
        if (r_aux_cnt == PRE_LAST) begin
          w_state_nxt = SFD;
        end
      end
      SFD: begin
        w_tx_en_nxt    = 1'b1;
        w_tx_data_nxt  = SFD_BYTE;
        w_crc_nxt      = CRC32_INIT;
        w_byte_cnt_nxt = '0;
        w_aux_cnt_nxt  = '0;
        w_state_nxt    = DATA;
      end
      DATA: begin
        w_s_ready = 1'b1;
        if (s_valid) begin
          w_tx_en_nxt    = 1'b1;
          w_tx_data_nxt  = s_data;
          w_crc_nxt      = crc32_byte(r_crc, s_data);
          w_byte_cnt_nxt = w_byte_cnt_inc;
          if (s_last) begin
            w_state_nxt = (w_byte_cnt_inc < PAD_LIMIT) ? PAD : FCS;
          end else if (w_byte_cnt_inc == OVERSIZE_LIMIT) begin
            w_tx_er_nxt = 1'b1;
            w_err_nxt   = 1'b1;
            w_state_nxt = DRAIN;
          end
        end else begin
          // Source ran dry mid-frame: poison the frame on the wire and abandon it.
          w_tx_en_nxt = 1'b1;
          w_tx_er_nxt = 1'b1;
          w_err_nxt   = 1'b1;
          w_state_nxt = IFG;
        end
      end
      PAD: begin
        w_tx_en_nxt    = 1'b1;
        w_crc_nxt      = crc32_byte(r_crc, 8'h00);
        w_byte_cnt_nxt = w_byte_cnt_inc;
        if (w_byte_cnt_inc == PAD_LIMIT) begin
          w_state_nxt = FCS;
        end
      end
      FCS: begin
        w_tx_en_nxt   = 1'b1;
        w_tx_data_nxt = w_fcs_shift[7:0];
        w_aux_cnt_nxt = r_aux_cnt + AUX_W'(1);
        if (r_aux_cnt == FCS_LAST) begin
          w_aux_cnt_nxt  = '0;
          w_fcs_last_nxt = 1'b1;
          w_state_nxt    = IFG;
        end
      end
      DRAIN: begin
        w_s_ready = 1'b1;
        if (s_valid && s_last) begin
          w_state_nxt = IFG;
        end
      end
      IFG: begin
        w_aux_cnt_nxt = r_aux_cnt + AUX_W'(1);
        if (r_aux_cnt == IFG_LAST) begin
          w_aux_cnt_nxt = '0;
          w_state_nxt   = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, CRC and registered PHY outputs; frame_done trails the last FCS byte by one clock.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_byte_cnt   <= '0;
      r_aux_cnt    <= '0;
      r_crc        <= CRC32_INIT;
      r_tx_data    <= '0;
      r_tx_en      <= 1'b0;
      r_tx_er      <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_fcs_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_aux_cnt    <= w_aux_cnt_nxt;
      r_crc        <= w_crc_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_tx_en      <= w_tx_en_nxt;
      r_tx_er      <= w_tx_er_nxt;
      r_err_pulse  <= w_err_nxt;
      r_fcs_last   <= w_fcs_last_nxt;
      r_frame_done <= r_fcs_last;
    end
  end

  assign s_ready    = w_s_ready;
  assign tx_data    = r_tx_data;
  assign tx_en      = r_tx_en;
  assign tx_er      = r_tx_er;
  assign err_pulse  = r_err_pulse;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - self-checking bench for eth_tx_framer
module tb_eth_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n_in;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_er;
  logic       frame_done;
  logic       err_pulse;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  eth_tx_framer #(.IFG_BYTES(12), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n_in   (rst_n_in),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_er      (tx_er),
    .frame_done (frame_done),
    .err_pulse  (err_pulse)
  );

  // Wire monitor
  logic [7:0] tx_q[$];
  bit         er_q[$];
  int         gaps[$];
  int         done_cnt, err_cnt, err_aligned, low_run;
  bit         seen_high;

  initial begin
    forever begin
      @(negedge clk);
      if (tx_en === 1'b1) begin
        tx_q.push_back(tx_data);
        er_q.push_back(tx_er === 1'b1);
        if (seen_high && low_run > 0) gaps.push_back(low_run);
        low_run   = 0;
        seen_high = 1'b1;
      end else if (seen_high) begin
        low_run++;
      end
      if (frame_done === 1'b1) done_cnt++;
      if (err_pulse === 1'b1) begin
        err_cnt++;
        if (tx_en === 1'b1 && tx_er === 1'b1) err_aligned++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    tx_q.delete(); er_q.delete(); gaps.delete();
    done_cnt = 0; err_cnt = 0; err_aligned = 0; low_run = 0; seen_high = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: bit-serial LFSR over the whole message, LSB of each byte first.
  function automatic logic [31:0] ref_crc_reg(input logic [7:0] m[$]);
    logic [31:0] r;
    bit fb;
    r = 32'hFFFFFFFF;
    foreach (m[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = r[0] ^ m[i][b];
        r  = r >> 1;
        if (fb) r = r ^ 32'hEDB88320;
      end
    end
    return r;
  endfunction

  logic [7:0] exp_q[$];

  // Append the expected wire image of a good frame carrying this payload.
  task automatic add_expected(input logic [7:0] pay[$]);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    body = pay;
    while (body.size() < 60) body.push_back(8'h00);
    fcs = ~ref_crc_reg(body);
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
  endtask

  task automatic compare_stream(input string tag);
    int bad, ers;
    bad = 0; ers = 0;
    chk({tag, "_len"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      if (tx_q[i] !== exp_q[i]) bad++;
    foreach (er_q[i]) if (er_q[i]) ers++;
    chk({tag, "_bad_bytes"}, bad, 0);
    chk({tag, "_tx_er_bytes"}, ers, 0);
  endtask

  // Present payload bytes under valid/ready; stop_at >= 0 withholds s_last and drops valid after that many.
  task automatic send(input logic [7:0] pay[$], input int stop_at, output int accepted);
    int  i, n, lim, budget;
    bit  rdy;
    i = 0; budget = 0; n = pay.size();
    lim = (stop_at >= 0) ? stop_at : n;
    s_valid = 1'b1; s_data = pay[0]; s_last = (stop_at < 0 && n == 1);
    while (i < lim && budget < 4 * n + 200) begin
      @(negedge clk);
      rdy = (s_ready === 1'b1);
      @(posedge clk);
      #1;
      budget++;
      if (rdy) begin
        i++;
        if (i < lim) begin
          s_data = pay[i];
          s_last = (stop_at < 0 && i == n - 1);
        end
      end
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    accepted = i;
  endtask

  task automatic rand_payload(input int len, output logic [7:0] pay[$]);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
  endtask

  task automatic settle();
    repeat (90) @(posedge clk);
    #1;
  endtask

  logic [7:0] pay[$];
  logic [7:0] pay2[$];
  logic [7:0] fr[$];
  int         acc, acc2, len, ers, bad, hit;
  string      digits;

  initial begin
    rst_n_in = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    clear_mon();
    #3;
    chk("reset_tx_en", tx_en, 1'b0);
    chk("reset_tx_er", tx_er, 1'b0);
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_s_ready", s_ready, 1'b0);
    chk("reset_frame_done", frame_done, 1'b0);
    chk("reset_err_pulse", err_pulse, 1'b0);
    @(posedge clk); #1;
    rst_n_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_s_ready", s_ready, 1'b0);
    chk("idle_tx_en", tx_en, 1'b0);

    // 14-byte payload: padded to 60, 72 clocks of tx_en
    clear_mon(); exp_q.delete();
    rand_payload(14, pay);
    add_expected(pay);
    send(pay, -1, acc);
    settle();
    chk("p14_accepted", acc, 14);
    compare_stream("p14");
    chk("p14_tx_en_clocks", tx_q.size(), 72);
    chk("p14_frame_done", done_cnt, 1);
    chk("p14_err", err_cnt, 0);

    // 51 random bytes + "123456789": no pad, check latency and receiver residue
    clear_mon(); exp_q.delete();
    rand_payload(51, pay);
    digits = "123456789";
    for (int i = 0; i < digits.len(); i++) pay.push_back(digits[i]);
    add_expected(pay);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = pay[0]; s_last = 1'b0;
    @(negedge clk);
    chk("lat_before_edge_tx_en", tx_en, 1'b0);
    @(negedge clk);
    chk("lat_first_tx_en", tx_en, 1'b1);
    chk("lat_first_byte", tx_data, 8'h55);
    send(pay, -1, acc);
    settle();
    compare_stream("ascii");
    fr.delete();
    for (int i = 8; i < tx_q.size(); i++) fr.push_back(tx_q[i]);
    chk("ascii_residue", ref_crc_reg(fr), 32'hDEBB20E3);
    chk("ascii_frame_done", done_cnt, 1);

    // Pad boundary lengths and random lengths
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: len = 1;
        1: len = 59;
        2: len = 60;
        3: len = 61;
        default: len = $urandom_range(2, 120);
      endcase
      clear_mon(); exp_q.delete();
      rand_payload(len, pay);
      add_expected(pay);
      send(pay, -1, acc);
      settle();
      compare_stream($sformatf("len%0d", len));
      chk($sformatf("len%0d_frame_done", len), done_cnt, 1);
    end

    // Back-to-back frames with valid held high
    clear_mon(); exp_q.delete();
    rand_payload(60, pay);
    rand_payload(60, pay2);
    add_expected(pay);
    add_expected(pay2);
    send(pay, -1, acc);
    send(pay2, -1, acc2);
    settle();
    compare_stream("b2b");
    chk("b2b_gap_count", gaps.size(), 1);
    chk("b2b_gap_len", (gaps.size() > 0) ? gaps[0] : -1, 12);
    chk("b2b_frame_done", done_cnt, 2);

    // Underrun after 20 bytes
    clear_mon();
    rand_payload(40, pay);
    send(pay, 20, acc);
    settle();
    chk("ur_len", tx_q.size(), 29);
    ers = 0;
    foreach (er_q[i]) if (er_q[i]) ers++;
    chk("ur_er_count", ers, 1);
    chk("ur_er_last", (er_q.size() == 29) ? er_q[28] : 1'b0, 1'b1);
    chk("ur_err_byte", (tx_q.size() == 29) ? tx_q[28] : 8'hFF, 8'h00);
    bad = 0;
    for (int i = 0; i < 20 && i + 8 < tx_q.size(); i++) if (tx_q[i + 8] !== pay[i]) bad++;
    chk("ur_payload_bad", bad, 0);
    chk("ur_err_pulse", err_cnt, 1);
    chk("ur_err_aligned", err_aligned, 1);
    chk("ur_frame_done", done_cnt, 0);

    // Oversize: 1600-byte payload
    clear_mon();
    rand_payload(1600, pay);
    send(pay, -1, acc);
    settle();
    chk("ovs_accepted", acc, 1600);
    chk("ovs_len", tx_q.size(), 1522);
    ers = 0;
    foreach (er_q[i]) if (er_q[i]) ers++;
    chk("ovs_er_count", ers, 1);
    chk("ovs_er_at_1514", (er_q.size() == 1522) ? er_q[1521] : 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < 1514 && i + 8 < tx_q.size(); i++) if (tx_q[i + 8] !== pay[i]) bad++;
    chk("ovs_payload_bad", bad, 0);
    chk("ovs_err_pulse", err_cnt, 1);
    chk("ovs_err_aligned", err_aligned, 1);
    chk("ovs_frame_done", done_cnt, 0);

    // Reset during second FCS byte, then a clean frame
    clear_mon(); exp_q.delete();
    rand_payload(14, pay);
    add_expected(pay);
    send(pay, -1, acc);
    hit = 0;
    for (int c = 0; c < 200 && hit == 0; c++) begin
      @(negedge clk);
      if (tx_q.size() == 70) hit = 1;
    end
    chk("rst_reached_fcs2", hit, 1);
    chk("rst_fcs0", (tx_q.size() >= 70) ? tx_q[68] : 8'hXX, exp_q[68]);
    chk("rst_fcs1", (tx_q.size() >= 70) ? tx_q[69] : 8'hXX, exp_q[69]);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("rst_async_tx_en", tx_en, 1'b0);
    chk("rst_async_tx_er", tx_er, 1'b0);
    chk("rst_async_tx_data", tx_data, 8'h00);
    chk("rst_async_s_ready", s_ready, 1'b0);
    @(posedge clk); #1;
    rst_n_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_frame_done", done_cnt, 0);
    chk("rst_no_err", err_cnt, 0);
    clear_mon(); exp_q.delete();
    rand_payload($urandom_range(10, 70), pay);
    add_expected(pay);
    send(pay, -1, acc);
    settle();
    compare_stream("post_rst");
    chk("post_rst_frame_done", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
